// File: rtl/if_fetch_pkg.sv
// Shared fetch-FSM encodings so ctrl and debug logic decode the IF state identically.
package if_fetch_pkg;
  localparam logic [2:0] IF_ST_ISSUE0 = 3'd0;
  localparam logic [2:0] IF_ST_ISSUE1 = 3'd1;
  localparam logic [2:0] IF_ST_ISSUE2 = 3'd2;
  localparam logic [2:0] IF_ST_ISSUE3 = 3'd3;
  localparam logic [2:0] IF_ST_LAST   = 3'd4;
  localparam logic [2:0] IF_ST_DELIV  = 3'd5;

  // ISSUEk encodings equal k, so state[1:0] doubles as the byte offset.
  function automatic logic is_issue(input logic [2:0] st);
    return st <= IF_ST_ISSUE3;
  endfunction
endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: reads one 32-bit instruction as four byte reads over the shared
// memory port, then offers {pc, inst} to IF/ID until it is accepted.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_address_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_grant_i,
  input  logic [7:0]        mem_din_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o
);
  logic [2:0]      r_state;
  logic [31:0]     r_pc;
  logic [3:0][7:0] r_b;
  logic            r_pend;
  logic [31:0]     r_pc_o;
  logic [31:0]     r_inst_o;

  logic        w_redirect;
  logic        w_grant;
  logic        w_cap;
  logic [2:0]  w_prev;
  logic [31:0] w_byte_addr;

  // A branch under a load-use stall is dropped; ID re-asserts it after the stall.
  assign w_redirect  = branch_flag_i & ~stall_i;
  assign w_byte_addr = r_pc + {30'd0, r_state[1:0]};
  assign mem_req_o   = is_issue(r_state) & ~rst;
  assign mem_addr_o  = mem_req_o ? w_byte_addr[ADDR_W-1:0] : '0;
  assign w_grant     = mem_req_o & mem_grant_i;

  // Data for the request granted last cycle lands now; r_pend makes a held cycle capture once.
  assign w_prev = r_state - 3'd1;
  assign w_cap  = r_pend & (r_state >= IF_ST_ISSUE1) & (r_state <= IF_ST_LAST);

  assign pc_o         = r_pc_o;
  assign inst_o       = r_inst_o;
  assign inst_valid_o = (r_state == IF_ST_DELIV) & ~stall_i & ~branch_flag_i & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IF_ST_ISSUE0;
      r_pc     <= RESET_PC;
      r_b      <= '0;
      r_pend   <= 1'b0;
      r_pc_o   <= '0;
      r_inst_o <= '0;
    end else if (w_redirect) begin
      r_state <= IF_ST_ISSUE0;
      r_pc    <= branch_target_address_i;
      r_b     <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= w_grant;
      if (w_cap) r_b[w_prev[1:0]] <= mem_din_i;
      case (r_state)
        IF_ST_ISSUE0, IF_ST_ISSUE1, IF_ST_ISSUE2, IF_ST_ISSUE3:
          if (w_grant) r_state <= r_state + 3'd1;
        IF_ST_LAST: begin
          r_state  <= IF_ST_DELIV;
          r_pc_o   <= r_pc;
          r_inst_o <= {mem_din_i, r_b[2], r_b[1], r_b[0]};
        end
        IF_ST_DELIV:
          if (!stall_i) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= IF_ST_ISSUE0;
          end
        default: r_state <= IF_ST_ISSUE0;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed latency/stall/redirect/reset scenarios, then randomized
// grant/stall/branch traffic checked against a program-order model of delivered instructions.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        grant;
  logic [7:0]  din;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid;

  int checks = 0;
  int errors = 0;

  if_fetch #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
    .branch_target_address_i(target), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_grant_i(grant), .mem_din_i(din), .pc_o(pc_o), .inst_o(inst_o),
    .inst_valid_o(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [31:0] a);
    logic [31:0] first;
    first = 32'h0010_0513;
    if (a < 32'd4) return first[8*a[1:0] +: 8];
    return 8'(a * 7) ^ 8'((a >> 8) * 13) ^ 8'h5A;
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {memf(a + 32'd3), memf(a + 32'd2), memf(a + 32'd1), memf(a)};
  endfunction

  // Byte-wide memory: data one cycle after a granted request, junk otherwise.
  always @(posedge clk) din <= (mem_req && grant) ? memf(mem_addr) : 8'($urandom);

  task automatic advance(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; grant = 1'b1; stall = 1'b0; branch = 1'b0; target = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!valid && cyc < budget) begin @(negedge clk); #1; cyc++; end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; grant = 1'b1; stall = 1'b0; branch = 1'b0; target = '0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    checks++; if (pc_o !== 32'h0)     begin errors++; $display("FAIL reset_pc got %h want 0", pc_o); end
    checks++; if (inst_o !== 32'h0)   begin errors++; $display("FAIL reset_inst got %h want 0", inst_o); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
  endtask

  task automatic test_first_fetch();
    int c;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0)
      begin errors++; $display("FAIL first_req got %b/%h want 1/0", mem_req, mem_addr); end
    wait_valid(20, c);
    checks++; if (c + 1 !== 6) begin errors++; $display("FAIL first_latency got %0d want 6", c + 1); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL first_pc got %h want 0", pc_o); end
    checks++; if (inst_o !== 32'h0010_0513)
      begin errors++; $display("FAIL first_inst got %h want 00100513", inst_o); end
    advance(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_pulse got %b want 0", valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4)
      begin errors++; $display("FAIL first_next got %b/%h want 1/4", mem_req, mem_addr); end
  endtask

  task automatic test_grant_hold();
    int held, c;
    do_reset();
    held = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); grant = (i == 3); #1;
      if (mem_req && mem_addr == 32'h1) held++;
    end
    @(negedge clk); grant = 1'b1; #1;
    checks++; if (held !== 4) begin errors++; $display("FAIL hold_addr got %0d cycles want 4", held); end
    wait_valid(20, c);
    checks++; if (c + 6 !== 9) begin errors++; $display("FAIL hold_latency got %0d want 9", c + 6); end
    checks++; if (inst_o !== 32'h0010_0513)
      begin errors++; $display("FAIL hold_inst got %h want 00100513", inst_o); end
  endtask

  task automatic test_stall_deliv();
    int pulses;
    do_reset();
    advance(4);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); stall = 1'b1; #1;
      if (valid) pulses++;
      checks++; if (pc_o !== 32'h0 || inst_o !== 32'h0010_0513)
        begin errors++; $display("FAIL stall_hold got %h/%h want 0/00100513", pc_o, inst_o); end
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL stall_valid got %0d want 0", pulses); end
    @(negedge clk); stall = 1'b0; #1;
    checks++; if (valid !== 1'b1 || pc_o !== 32'h0)
      begin errors++; $display("FAIL stall_release got %b/%h want 1/0", valid, pc_o); end
    advance(1);
    checks++; if (valid !== 1'b0 || mem_addr !== 32'h4)
      begin errors++; $display("FAIL stall_next got %b/%h want 0/4", valid, mem_addr); end
  endtask

  task automatic test_branch_issue2();
    int c;
    do_reset();
    advance(1);
    @(negedge clk); branch = 1'b1; target = 32'h100; #1;
    checks++; if (mem_addr !== 32'h2) begin errors++; $display("FAIL br_state got %h want 2", mem_addr); end
    @(negedge clk); branch = 1'b0; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100)
      begin errors++; $display("FAIL br_req got %b/%h want 1/100", mem_req, mem_addr); end
    wait_valid(20, c);
    checks++; if (c !== 5) begin errors++; $display("FAIL br_latency got %0d want 5", c); end
    checks++; if (pc_o !== 32'h100 || inst_o !== memword(32'h100))
      begin errors++; $display("FAIL br_deliver got %h/%h want 100/%h", pc_o, inst_o, memword(32'h100)); end
  endtask

  task automatic test_branch_stall();
    int c;
    do_reset();
    advance(4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); stall = 1'b1; branch = 1'b1; target = 32'h200; #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bs_valid got %b want 0", valid); end
    end
    @(negedge clk); stall = 1'b0; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bs_drop got %b want 0", valid); end
    @(negedge clk); branch = 1'b0; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200)
      begin errors++; $display("FAIL bs_redirect got %b/%h want 1/200", mem_req, mem_addr); end
    wait_valid(20, c);
    checks++; if (valid !== 1'b1 || pc_o !== 32'h200 || inst_o !== memword(32'h200))
      begin errors++; $display("FAIL bs_deliver got %b/%h/%h want 1/200/%h", valid, pc_o, inst_o, memword(32'h200)); end
  endtask

  task automatic test_reset_midfetch();
    int c;
    advance(4);
    checks++; if (mem_addr !== 32'h207) begin errors++; $display("FAIL rm_state got %h want 207", mem_addr); end
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || pc_o !== 32'h0 || inst_o !== 32'h0 || valid !== 1'b0)
      begin errors++; $display("FAIL rm_outputs got %b/%h/%h/%h/%b want all 0", mem_req, mem_addr, pc_o, inst_o, valid); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0)
      begin errors++; $display("FAIL rm_req got %b/%h want 1/0", mem_req, mem_addr); end
    wait_valid(20, c);
    checks++; if (c !== 5 || pc_o !== 32'h0 || inst_o !== 32'h0010_0513)
      begin errors++; $display("FAIL rm_deliver got %0d/%h/%h want 5/0/00100513", c, pc_o, inst_o); end
  endtask

  // Model: deliveries appear in program order from the last taken redirect, one per fetched word.
  task automatic test_random();
    logic [31:0] exp_pc;
    int          delivered;
    do_reset();
    exp_pc = 32'h0;
    delivered = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      grant  = ($urandom_range(0, 9) < 7);
      stall  = ($urandom_range(0, 9) < 2);
      branch = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 2))
        0:       target = 32'hFFFF_FFFC;
        1:       target = {20'h0, 10'($urandom), 2'b00};
        default: target = $urandom;
      endcase
      #1;
      if (stall || branch) begin
        checks++; if (valid !== 1'b0)
          begin errors++; $display("FAIL rnd_block cyc %0d got %b want 0", i, valid); end
      end
      if (valid) begin
        delivered++;
        checks++; if (pc_o !== exp_pc)
          begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc_o, exp_pc); end
        checks++; if (inst_o !== memword(exp_pc))
          begin errors++; $display("FAIL rnd_inst cyc %0d got %h want %h", i, inst_o, memword(exp_pc)); end
      end
      if (branch && !stall) exp_pc = target;
      else if (valid)       exp_pc = exp_pc + 32'd4;
    end
    checks++; if (delivered < 100)
      begin errors++; $display("FAIL rnd_progress got %0d want >=100", delivered); end
    @(negedge clk); stall = 1'b0; branch = 1'b0; grant = 1'b1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; target = '0; grant = 1'b1;
    test_reset();
    test_first_fetch();
    test_grant_hold();
    test_stall_deliv();
    test_branch_issue2();
    test_branch_stall();
    test_reset_midfetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
